control_unit: RTL and testbench

Fetch/decode/execute sequencer for the 8-bit processor. It drives the instruction register write enable, the program counter, memory requests and accumulator/ALU strobes from the opcode held in the instruction register. It sits between the instruction memory/data memory handshake and the datapath registers (IR, PC, ACC, ALU) and is the only source of their enables.

---
 rtl/cu_pkg.sv | 61 ++++++
 rtl/control_unit_if.sv | 22 ++
 rtl/cu_ack_timer.sv | 33 +++
 rtl/control_unit.sv | 162 ++++++++++++++++
 tb/tb_control_unit.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the 8-bit processor control unit: opcodes, FSM state
// codes, ALU operation codes and small decode helpers.
package cu_pkg;

  localparam int STATE_W = 3;
  localparam int OPC_W   = 4;
  localparam int CNT_W   = 4;

  // state      | meaning
  // IDLE   (0) | one dead cycle after reset, then start fetching
  // FETCH  (1) | instruction memory request at PC, wait for ack
  // DECODE (2) | IR valid; branch, halt or dispatch to MEM
  // MEM    (3) | operand access at IR[3:0]; load/store/ALU on ack
  // HALT   (4) | HLT executed; terminal until reset
  // FAULT  (5) | memory ack timeout or bad state; terminal until reset
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } cu_state_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_op_e;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_STA = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h4;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h5;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h6;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  // Opcodes that need an operand memory access.
  function automatic logic needs_mem(input logic [OPC_W-1:0] op);
    return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Opcodes that write the accumulator when the operand arrives.
  function automatic logic writes_acc(input logic [OPC_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // ALU function selected for an accumulator-writing opcode.
  function automatic alu_op_e alu_for(input logic [OPC_W-1:0] op);
    alu_op_e res;
    case (op)
      OP_ADD:  res = ALU_ADD;
      OP_SUB:  res = ALU_SUB;
      default: res = ALU_PASS;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Memory handshake between the control unit and the instruction/data memory.
// Address itself comes from the datapath mux; only its select travels here.
interface control_unit_if;
  logic CU_mem_req;
  logic CU_mem_we;
  logic CU_addr_sel;
  logic CU_mem_ack;

  modport master (
    output CU_mem_req,
    output CU_mem_we,
    output CU_addr_sel,
    input  CU_mem_ack
  );

  modport slave (
    input  CU_mem_req,
    input  CU_mem_we,
    input  CU_addr_sel,
    output CU_mem_ack
  );
endinterface

// File: rtl/cu_ack_timer.sv
// Memory ack wait counter. Counts request cycles without ack and flags the
// cycle on which one more miss would reach ACK_TIMEOUT, so the FSM can go to
// FAULT on that very cycle unless ack arrives (ack wins).
module cu_ack_timer
  import cu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic CU_clk,
  input  logic CU_rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Wait counter: cleared on every state change, steps on each missed ack.
  always_ff @(posedge CU_clk or negedge CU_rst_n) begin
    if (!CU_rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout = (cnt_q == LAST_WAIT);

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer. Mealy strobes decoded from state, the IR
// opcode, the zero flag and memory ack; state, wait counter and the sticky
// illegal-opcode flag are registered.
module control_unit
  import cu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                CU_clk,
  input  logic                CU_rst_n,
  input  logic [7:0]          CU_ir,
  input  logic                CU_zero,
  control_unit_if.master      mem,
  output logic                CU_ir_we,
  output logic                CU_pc_inc,
  output logic                CU_pc_load,
  output logic [1:0]          CU_alu_op,
  output logic                CU_acc_we,
  output logic                CU_halt,
  output logic                CU_illegal,
  output logic [STATE_W-1:0]  CU_state
);

  cu_state_e        state_q;
  cu_state_e        state_nxt;
  logic [OPC_W-1:0] opcode;
  logic             ack;
  logic             timeout;
  logic             wait_en;
  logic             illegal_set;
  logic             illegal_q;

  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;

  // The operand field drives the datapath address mux directly.
  logic             ir_operand_unused;

  assign opcode            = CU_ir[7:4];
  assign ir_operand_unused = ^CU_ir[3:0];
  assign ack               = mem.CU_mem_ack;

  cu_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .CU_clk   (CU_clk),
    .CU_rst_n (CU_rst_n),
    .clr      (state_nxt != state_q),
    .en       (wait_en),
    .timeout  (timeout)
  );

  // State register.
  always_ff @(posedge CU_clk or negedge CU_rst_n) begin
    if (!CU_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Sticky illegal-opcode flag; only reset clears it.
  always_ff @(posedge CU_clk or negedge CU_rst_n) begin
    if (!CU_rst_n) begin
      illegal_q <= 1'b0;
    end else if (illegal_set) begin
      illegal_q <= 1'b1;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt   = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    CU_ir_we    = 1'b0;
    CU_pc_inc   = 1'b0;
    CU_pc_load  = 1'b0;
    CU_alu_op   = ALU_PASS;
    CU_acc_we   = 1'b0;
    CU_halt     = 1'b0;
    wait_en     = 1'b0;
    illegal_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req = 1'b1;
        if (ack) begin
          CU_ir_we  = 1'b1;
          CU_pc_inc = 1'b1;
          state_nxt = ST_DECODE;
        end else begin
          wait_en = 1'b1;
          if (timeout) begin
            state_nxt = ST_FAULT;
          end
        end
      end

      ST_DECODE: begin
        if (needs_mem(opcode)) begin
          state_nxt = ST_MEM;
        end else begin
          case (opcode)
            OP_NOP: state_nxt = ST_FETCH;
            OP_JMP: begin
              CU_pc_load = 1'b1;
              state_nxt  = ST_FETCH;
            end
            OP_JZ: begin
              CU_pc_load = CU_zero;
              state_nxt  = ST_FETCH;
            end
            OP_HLT: state_nxt = ST_HALT;
            default: begin
              // Undefined opcode: flag it and carry on as a NOP.
              illegal_set = 1'b1;
              state_nxt   = ST_FETCH;
            end
          endcase
        end
      end

      ST_MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = (opcode == OP_STA);
        CU_alu_op = alu_for(opcode);
        if (ack) begin
          CU_acc_we = writes_acc(opcode);
          state_nxt = ST_FETCH;
        end else begin
          wait_en = 1'b1;
          if (timeout) begin
            state_nxt = ST_FAULT;
          end
        end
      end

      ST_HALT, ST_FAULT: begin
        CU_halt = 1'b1;
      end

      default: begin
        state_nxt = ST_FAULT;
      end
    endcase
  end

  assign mem.CU_mem_req  = mem_req;
  assign mem.CU_mem_we   = mem_we;
  assign mem.CU_addr_sel = addr_sel;
  assign CU_illegal      = illegal_q;
  assign CU_state        = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: plays instruction/data memory and the IR register,
// and checks per-cycle state and strobes against hand-derived expectations.
module tb_control_unit;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2,
                         S_MEM  = 3'd3, S_HALT  = 3'd4, S_FAULT = 3'd5;

  // bits: ir_we pc_inc pc_load mem_req mem_we addr_sel alu[1:0] acc_we halt illegal
  localparam logic [10:0] B0      = 11'h000;
  localparam logic [10:0] B_FW    = 11'h080;
  localparam logic [10:0] B_FA    = 11'h680;
  localparam logic [10:0] B_LD    = 11'h100;
  localparam logic [10:0] B_MW    = 11'h0A0;
  localparam logic [10:0] B_LDA_A = 11'h0A4;
  localparam logic [10:0] B_ADD_A = 11'h0AC;
  localparam logic [10:0] B_SUB_W = 11'h0B0;
  localparam logic [10:0] B_SUB_A = 11'h0B4;
  localparam logic [10:0] B_STA   = 11'h0E0;
  localparam logic [10:0] B_H     = 11'h002;
  localparam logic [10:0] ILL     = 11'h001;

  typedef struct packed {
    logic        ack;
    logic        zero;
    logic [7:0]  d;
    logic [2:0]  st;
    logic [10:0] b;
  } row_t;

  logic       CU_clk   = 1'b0;
  logic       CU_rst_n = 1'b0;
  logic [7:0] CU_ir;
  logic       CU_zero  = 1'b0;
  logic       CU_ir_we, CU_pc_inc, CU_pc_load, CU_acc_we, CU_halt, CU_illegal;
  logic [1:0] CU_alu_op;
  logic [2:0] CU_state;
  logic [7:0] rdata = 8'h00;
  logic [7:0] ir_q  = 8'h00;

  int checks   = 0;
  int failures = 0;
  logic [13:0] sb[$];

  control_unit_if mem_bus();

  control_unit #(.ACK_TIMEOUT(3)) dut (
    .CU_clk     (CU_clk),
    .CU_rst_n   (CU_rst_n),
    .CU_ir      (CU_ir),
    .CU_zero    (CU_zero),
    .mem        (mem_bus.master),
    .CU_ir_we   (CU_ir_we),
    .CU_pc_inc  (CU_pc_inc),
    .CU_pc_load (CU_pc_load),
    .CU_alu_op  (CU_alu_op),
    .CU_acc_we  (CU_acc_we),
    .CU_halt    (CU_halt),
    .CU_illegal (CU_illegal),
    .CU_state   (CU_state)
  );

  always #5 CU_clk = ~CU_clk;

  // Instruction register model: captures memory read data on the ack edge.
  always @(posedge CU_clk) if (CU_ir_we) ir_q <= rdata;
  assign CU_ir = ir_q;

  initial mem_bus.CU_mem_ack = 1'b0;

  function automatic logic [13:0] obs();
    return {CU_state, CU_ir_we, CU_pc_inc, CU_pc_load, mem_bus.CU_mem_req,
            mem_bus.CU_mem_we, mem_bus.CU_addr_sel, CU_alu_op, CU_acc_we,
            CU_halt, CU_illegal};
  endfunction

  function automatic row_t r(input logic a, input logic z, input logic [7:0] d,
                             input logic [2:0] s, input logic [10:0] b);
    return {a, z, d, s, b};
  endfunction

  // Drive one cycle's inputs after the falling edge and queue its expectation.
  task automatic drive(input row_t rw);
    @(negedge CU_clk);
    mem_bus.CU_mem_ack = rw.ack;
    CU_zero = rw.zero;
    rdata   = rw.d;
    sb.push_back({rw.st, rw.b});
    #1;
  endtask

  task automatic release_reset();
    @(posedge CU_clk);
    #2 CU_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [13:0] got;
    CU_rst_n = 1'b0;
    mem_bus.CU_mem_ack = 1'b1;
    CU_zero = 1'b1;
    #3;
    got = obs(); checks++;
    if (got !== 14'd0) begin failures++;
      $display("FAIL reset_async: got %b expected 0", got); end
    repeat (2) @(posedge CU_clk);
    #1;
    got = obs(); checks++;
    if (got !== 14'd0) begin failures++;
      $display("FAIL reset_held: got %b expected 0", got); end
    release_reset();
  endtask

  task automatic test_nop_stream();
    row_t rows[$];
    logic [13:0] got, exp;
    rows.push_back(r(1, 0, 8'h00, S_IDLE,  B0));
    for (int k = 0; k < 3; k++) begin
      rows.push_back(r(1, 0, 8'h00, S_FETCH, B_FA));
      rows.push_back(r(1, 0, 8'h00, S_DEC,   B0));
    end
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front(); got = obs(); checks++;
      if (got !== exp) begin failures++;
        $display("FAIL nop_stream row %0d: got st=%0d b=%b expected st=%0d b=%b",
                 i, got[13:11], got[10:0], exp[13:11], exp[10:0]); end
    end
  endtask

  task automatic test_lda_wait();
    row_t rows[$];
    logic [13:0] got, exp;
    rows.push_back(r(0, 0, 8'h13, S_FETCH, B_FW));
    rows.push_back(r(0, 0, 8'h13, S_FETCH, B_FW));
    rows.push_back(r(1, 0, 8'h13, S_FETCH, B_FA));
    rows.push_back(r(1, 0, 8'h00, S_DEC,   B0));
    rows.push_back(r(1, 0, 8'h00, S_MEM,   B_LDA_A));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front(); got = obs(); checks++;
      if (got !== exp) begin failures++;
        $display("FAIL lda_wait row %0d: got st=%0d b=%b expected st=%0d b=%b",
                 i, got[13:11], got[10:0], exp[13:11], exp[10:0]); end
    end
  endtask

  task automatic test_alu();
    row_t rows[$];
    logic [13:0] got, exp;
    rows.push_back(r(1, 0, 8'h35, S_FETCH, B_FA));
    rows.push_back(r(0, 0, 8'h00, S_DEC,   B0));
    rows.push_back(r(1, 0, 8'h00, S_MEM,   B_ADD_A));
    rows.push_back(r(1, 0, 8'h47, S_FETCH, B_FA));
    rows.push_back(r(0, 0, 8'h00, S_DEC,   B0));
    rows.push_back(r(0, 0, 8'h00, S_MEM,   B_SUB_W));
    rows.push_back(r(1, 0, 8'h00, S_MEM,   B_SUB_A));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front(); got = obs(); checks++;
      if (got !== exp) begin failures++;
        $display("FAIL alu row %0d: got st=%0d b=%b expected st=%0d b=%b",
                 i, got[13:11], got[10:0], exp[13:11], exp[10:0]); end
    end
  endtask

  task automatic test_store();
    row_t rows[$];
    logic [13:0] got, exp;
    rows.push_back(r(1, 0, 8'h29, S_FETCH, B_FA));
    rows.push_back(r(0, 0, 8'h00, S_DEC,   B0));
    rows.push_back(r(1, 0, 8'h00, S_MEM,   B_STA));
    rows.push_back(r(0, 0, 8'h00, S_FETCH, B_FW));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front(); got = obs(); checks++;
      if (got !== exp) begin failures++;
        $display("FAIL store row %0d: got st=%0d b=%b expected st=%0d b=%b",
                 i, got[13:11], got[10:0], exp[13:11], exp[10:0]); end
    end
  endtask

  task automatic test_jumps();
    row_t rows[$];
    logic [13:0] got, exp;
    rows.push_back(r(1, 1, 8'h6A, S_FETCH, B_FA));
    rows.push_back(r(0, 0, 8'h00, S_DEC,   B0));
    rows.push_back(r(1, 0, 8'h6A, S_FETCH, B_FA));
    rows.push_back(r(0, 1, 8'h00, S_DEC,   B_LD));
    rows.push_back(r(1, 0, 8'h5C, S_FETCH, B_FA));
    rows.push_back(r(0, 0, 8'h00, S_DEC,   B_LD));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front(); got = obs(); checks++;
      if (got !== exp) begin failures++;
        $display("FAIL jumps row %0d: got st=%0d b=%b expected st=%0d b=%b",
                 i, got[13:11], got[10:0], exp[13:11], exp[10:0]); end
    end
  endtask

  task automatic test_illegal_halt();
    row_t rows[$];
    logic [13:0] got, exp;
    rows.push_back(r(1, 0, 8'h80, S_FETCH, B_FA));
    rows.push_back(r(0, 0, 8'h00, S_DEC,   B0));
    rows.push_back(r(1, 0, 8'hF0, S_FETCH, B_FA | ILL));
    rows.push_back(r(1, 0, 8'h00, S_DEC,   ILL));
    rows.push_back(r(1, 0, 8'h00, S_HALT,  B_H | ILL));
    rows.push_back(r(1, 1, 8'h00, S_HALT,  B_H | ILL));
    rows.push_back(r(0, 0, 8'h00, S_HALT,  B_H | ILL));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front(); got = obs(); checks++;
      if (got !== exp) begin failures++;
        $display("FAIL illegal_halt row %0d: got st=%0d b=%b expected st=%0d b=%b",
                 i, got[13:11], got[10:0], exp[13:11], exp[10:0]); end
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    logic [13:0] got, exp;
    CU_rst_n = 1'b0;
    #1;
    got = obs(); checks++;
    if (got !== 14'd0) begin failures++;
      $display("FAIL reset_from_halt: got %b expected 0", got); end
    release_reset();
    rows.push_back(r(0, 0, 8'h00, S_IDLE,  B0));
    rows.push_back(r(0, 0, 8'h00, S_FETCH, B_FW));
    rows.push_back(r(0, 0, 8'h00, S_FETCH, B_FW));
    rows.push_back(r(0, 0, 8'h00, S_FETCH, B_FW));
    rows.push_back(r(0, 0, 8'h00, S_FAULT, B_H));
    rows.push_back(r(1, 0, 8'h00, S_FAULT, B_H));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front(); got = obs(); checks++;
      if (got !== exp) begin failures++;
        $display("FAIL timeout_fetch row %0d: got st=%0d b=%b expected st=%0d b=%b",
                 i, got[13:11], got[10:0], exp[13:11], exp[10:0]); end
    end
    mem_bus.CU_mem_ack = 1'b1;
    CU_rst_n = 1'b0;
    #1;
    got = obs(); checks++;
    if (got !== 14'd0) begin failures++;
      $display("FAIL reset_from_fault: got %b expected 0", got); end
    release_reset();
    rows.delete();
    rows.push_back(r(0, 0, 8'h00, S_IDLE,  B0));
    rows.push_back(r(0, 0, 8'h00, S_FETCH, B_FW));
    rows.push_back(r(0, 0, 8'h00, S_FETCH, B_FW));
    rows.push_back(r(1, 0, 8'h10, S_FETCH, B_FA));
    rows.push_back(r(0, 0, 8'h00, S_DEC,   B0));
    rows.push_back(r(0, 0, 8'h00, S_MEM,   B_MW));
    rows.push_back(r(0, 0, 8'h00, S_MEM,   B_MW));
    rows.push_back(r(1, 0, 8'h00, S_MEM,   B_LDA_A));
    rows.push_back(r(0, 0, 8'h00, S_FETCH, B_FW));
    rows.push_back(r(0, 0, 8'h00, S_FETCH, B_FW));
    rows.push_back(r(0, 0, 8'h00, S_FETCH, B_FW));
    rows.push_back(r(0, 0, 8'h00, S_FAULT, B_H));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front(); got = obs(); checks++;
      if (got !== exp) begin failures++;
        $display("FAIL timeout_ack_wins row %0d: got st=%0d b=%b expected st=%0d b=%b",
                 i, got[13:11], got[10:0], exp[13:11], exp[10:0]); end
    end
  endtask

  task automatic test_reset_mid_request();
    row_t rows[$];
    logic [13:0] got, exp;
    CU_rst_n = 1'b0;
    #1;
    release_reset();
    rows.push_back(r(0, 0, 8'h00, S_IDLE,  B0));
    rows.push_back(r(0, 0, 8'h00, S_FETCH, B_FW));
    rows.push_back(r(1, 0, 8'h29, S_FETCH, B_FA));
    rows.push_back(r(0, 0, 8'h00, S_DEC,   B0));
    rows.push_back(r(0, 0, 8'h00, S_MEM,   B_STA));
    foreach (rows[i]) begin
      drive(rows[i]);
      exp = sb.pop_front(); got = obs(); checks++;
      if (got !== exp) begin failures++;
        $display("FAIL mid_request row %0d: got st=%0d b=%b expected st=%0d b=%b",
                 i, got[13:11], got[10:0], exp[13:11], exp[10:0]); end
    end
    CU_rst_n = 1'b0;
    #1;
    got = obs(); checks++;
    if (got !== 14'd0) begin failures++;
      $display("FAIL reset_mid_mem: got %b expected 0", got); end
    release_reset();
  endtask

  initial begin
    test_reset();
    test_nop_stream();
    test_lda_wait();
    test_alu();
    test_store();
    test_jumps();
    test_illegal_halt();
    test_timeout();
    test_reset_mid_request();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
